// File: rtl/delay_mem_scheduler.sv
// Shares one single-port delay SRAM between NUM_TAPS ring-buffer taps: one read + one write per enabled tap per frame.
// Optional: define DELAY_MEM_CLEAR_EN to zero the whole SRAM after reset before frames are accepted.
module delay_mem_scheduler #(
    parameter int unsigned NUM_TAPS    = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         ADCLRCK,
    input  logic [NUM_TAPS*ADDR_W-1:0]   delay_time,
    input  logic [NUM_TAPS*DATA_W-1:0]   wr_data,
    input  logic [NUM_TAPS-1:0]          disabled,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [DATA_W-1:0]            ram_d,
    output logic                         ram_we,
    input  logic [DATA_W-1:0]            ram_q,
    output logic [NUM_TAPS*DATA_W-1:0]   rd_data,
    output logic                         rd_valid,
    output logic                         busy,
    output logic                         overrun
);
    localparam int unsigned TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int unsigned OW = ADDR_W - $clog2(NUM_TAPS);
    localparam logic [1:0]  WAIT_LAST = 2'(RAM_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE, CLEAR} state_t;

`ifdef DELAY_MEM_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
    logic [ADDR_W-1:0] clr_cnt;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t              state, state_nxt;
    logic [2:0]          adc_sync;
    logic                frame;
    logic [TW-1:0]       cur, nxt_tap;
    logic                nxt_found;
    logic [1:0]          wcnt;
    logic [OW-1:0]       wptr     [NUM_TAPS];
    logic [OW-1:0]       lat_d    [NUM_TAPS];
    logic [OW-1:0]       d_now    [NUM_TAPS];
    logic [DATA_W-1:0]   lat_data [NUM_TAPS];
    logic [DATA_W-1:0]   shadow   [NUM_TAPS];
    logic [NUM_TAPS-1:0] lat_dis, cand_mask;
    int unsigned         search_from;
    logic [OW-1:0]       d_sel, rd_off;
    logic [ADDR_W-1:0]   rd_addr, wr_addr;

    function automatic logic [OW-1:0] clamp_delay(input logic [ADDR_W-1:0] d);
        if ((d >> OW) != '0)
            return '1;
        else if (d == '0)
            return OW'(1);
        else
            return d[OW-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] tap_addr(input logic [TW-1:0] t, input logic [OW-1:0] off);
        return (ADDR_W'(t) << OW) | ADDR_W'(off);
    endfunction

    // Two sync flops, third flop for the rising-edge detect.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            adc_sync <= '0;
        else
            adc_sync <= {adc_sync[1:0], ADCLRCK};
    end
    assign frame = adc_sync[1] & ~adc_sync[2];
    assign busy  = (state != IDLE);

    always_comb begin
        for (int unsigned i = 0; i < NUM_TAPS; i++)
            d_now[i] = clamp_delay(delay_time[i*ADDR_W +: ADDR_W]);
    end

    // Outputs are registered one cycle ahead, so the next tap and its read address are
    // looked up while leaving IDLE or WR; in IDLE the live inputs are used since nothing is latched yet.
    always_comb begin
        cand_mask   = (state == IDLE) ? ~disabled : ~lat_dis;
        search_from = (state == IDLE) ? 32'd0 : 32'(cur) + 32'd1;
        nxt_found   = 1'b0;
        nxt_tap     = '0;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            if (!nxt_found && cand_mask[i] && i >= search_from) begin
                nxt_found = 1'b1;
                nxt_tap   = TW'(i);
            end
        end
        d_sel   = (state == IDLE) ? d_now[nxt_tap] : lat_d[nxt_tap];
        rd_off  = wptr[nxt_tap] - d_sel;
        rd_addr = tap_addr(nxt_tap, rd_off);
        wr_addr = tap_addr(cur, wptr[cur]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (frame) state_nxt = nxt_found ? RD : DONE;
            RD:    state_nxt = WAIT;
            WAIT:  if (wcnt == WAIT_LAST) state_nxt = WR;
            WR:    state_nxt = nxt_found ? RD : DONE;
            DONE:  state_nxt = IDLE;
`ifdef DELAY_MEM_CLEAR_EN
            CLEAR: if (clr_cnt == '1) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state <= RESET_STATE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cur      <= '0;
            wcnt     <= '0;
            lat_dis  <= '0;
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                wptr[i]     <= '0;
                lat_d[i]    <= '0;
                lat_data[i] <= '0;
                shadow[i]   <= '0;
            end
            ram_addr <= '0;
            ram_d    <= '0;
            ram_we   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overrun  <= 1'b0;
`ifdef DELAY_MEM_CLEAR_EN
            clr_cnt  <= '0;
`endif
        end else begin
            ram_we   <= 1'b0;
            rd_valid <= 1'b0;
            if (frame && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (frame) begin
                    lat_dis <= disabled;
                    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                        lat_d[i]    <= d_now[i];
                        lat_data[i] <= wr_data[i*DATA_W +: DATA_W];
                    end
                    if (nxt_found) begin
                        cur      <= nxt_tap;
                        ram_addr <= rd_addr;
                    end else begin
                        rd_data  <= '0;
                        rd_valid <= 1'b1;
                    end
                end
                RD: wcnt <= '0;
                WAIT: begin
                    wcnt <= wcnt + 2'd1;
                    if (wcnt == WAIT_LAST) begin
                        shadow[cur] <= ram_q;
                        ram_addr    <= wr_addr;
                        ram_d       <= lat_data[cur];
                        ram_we      <= 1'b1;
                    end
                end
                WR: begin
                    wptr[cur] <= wptr[cur] + OW'(1);
                    if (nxt_found) begin
                        cur      <= nxt_tap;
                        ram_addr <= rd_addr;
                    end else begin
                        for (int unsigned i = 0; i < NUM_TAPS; i++)
                            rd_data[i*DATA_W +: DATA_W] <= lat_dis[i] ? '0 : shadow[i];
                        rd_valid <= 1'b1;
                    end
                end
`ifdef DELAY_MEM_CLEAR_EN
                CLEAR: begin
                    ram_addr <= clr_cnt;
                    ram_d    <= '0;
                    ram_we   <= 1'b1;
                    clr_cnt  <= clr_cnt + ADDR_W'(1);
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_mem_scheduler.sv
// Bench for delay_mem_scheduler: directed frames plus random frames against a frame-level ring-buffer model.
module tb_delay_mem_scheduler;
    localparam int unsigned AW = 8;
    localparam int R = 128;
    localparam int L = 1;

    logic        clk = 1'b0;
    logic        rst, adc;
    logic [15:0] delay_time;
    logic [31:0] wr_data;
    logic [1:0]  disabled;
    logic [7:0]  ram_addr;
    logic [15:0] ram_d, ram_q;
    logic        ram_we;
    logic [31:0] rd_data;
    logic        rd_valid, busy, overrun;

    int total = 0;
    int bad = 0;

    logic [15:0] sram [256] = '{default: '0};
    logic [15:0] q_pipe = '0;

    int          mdl_wptr [2];
    logic [15:0] mdl_mem  [2][R];
    bit          exp_ovr;

    always #5 clk = ~clk;

    delay_mem_scheduler #(.NUM_TAPS(2), .ADDR_W(AW), .DATA_W(16), .RAM_LATENCY(L)) dut (
        .CLOCK_50(clk), .reset(rst), .ADCLRCK(adc), .delay_time(delay_time),
        .wr_data(wr_data), .disabled(disabled), .ram_addr(ram_addr), .ram_d(ram_d),
        .ram_we(ram_we), .ram_q(ram_q), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .overrun(overrun)
    );

    always @(posedge clk) begin
        if (ram_we) sram[ram_addr] <= ram_d;
        q_pipe <= sram[ram_addr];
    end
    assign ram_q = q_pipe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clampd(input int d);
        if (d == 0) return 1;
        if (d > R - 1) return R - 1;
        return d;
    endfunction

    // One frame: model predicts the access schedule and delayed samples, bench watches the SRAM bus.
    task automatic do_frame(input logic [1:0] dis, input int d0, input int d1,
                            input logic [15:0] w0, input logic [15:0] w1, input bit dbl);
        int e, n, wes, extra;
        int ra [2];
        int wa [2];
        logic [15:0] wd [2];
        logic [15:0] eq [2];
        int dd [2];
        logic [15:0] ww [2];
        bit got;
        dd[0] = d0; dd[1] = d1; ww[0] = w0; ww[1] = w1;
        e = 0;
        for (int i = 0; i < 2; i++) begin
            if (dis[i]) eq[i] = '0;
            else begin
                int dc, rs;
                dc = clampd(dd[i]);
                rs = (mdl_wptr[i] - dc + R) % R;
                eq[i] = mdl_mem[i][rs];
                ra[e] = i * R + rs;
                wa[e] = i * R + mdl_wptr[i];
                wd[e] = ww[i];
                mdl_mem[i][mdl_wptr[i]] = ww[i];
                mdl_wptr[i] = (mdl_wptr[i] + 1) % R;
                e++;
            end
        end
        if (dbl) exp_ovr = 1'b1;
        delay_time = {8'(d1), 8'(d0)};
        wr_data    = {w1, w0};
        disabled   = dis;
        @(negedge clk); #1 adc = 1'b1;
        n = 0; wes = 0; got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk); n++;
            if (dbl && n == 2) adc = 1'b0;
            if (dbl && n == 3) adc = 1'b1;
            if (n == 3) chk("busy_run", busy, 1);
            if (n == 4) disabled = ~dis;
            if (ram_we) wes++;
            for (int k = 0; k < e; k++) begin
                if (n == 3 + k * (2 + L)) begin
                    chk("rd_we", ram_we, 0);
                    chk("rd_addr", ram_addr, ra[k]);
                end
                if (n == 4 + L + k * (2 + L)) begin
                    chk("wr_we", ram_we, 1);
                    chk("wr_addr", ram_addr, wa[k]);
                    chk("wr_data", ram_d, wd[k]);
                end
            end
            if (rd_valid) got = 1'b1;
        end
        chk("valid_seen", got, 1);
        chk("valid_lat", n, 3 + e * (2 + L));
        chk("rd_data", rd_data, {eq[1], eq[0]});
        chk("we_count", wes, e);
        chk("overrun", overrun, exp_ovr);
        @(negedge clk);
        chk("valid_pulse", rd_valid, 0);
        chk("busy_idle", busy, 0);
        adc = 1'b0;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (ram_we || rd_valid) extra++;
        end
        chk("quiet_after", extra, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            mdl_wptr[i] = 0;
            for (int j = 0; j < R; j++) mdl_mem[i][j] = '0;
        end
        exp_ovr = 1'b0;
        rst = 1'b1; adc = 1'b0; delay_time = '0; wr_data = '0; disabled = '0;
        repeat (3) @(negedge clk);
        chk("rst_addr", ram_addr, 0);
        chk("rst_d", ram_d, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Tap0 delay 4 with an incrementing sample stream.
        for (int f = 1; f <= 6; f++) begin
            do_frame(2'b00, 4, 1, 16'(f), 16'(100 + f), 1'b0);
            chk("t1_tap0", rd_data[15:0], (f > 4) ? f - 4 : 0);
        end

        do_frame(2'b00, 0, 255, 16'h1111, 16'h2222, 1'b0);
        do_frame(2'b10, 3, 3, 16'h3333, 16'h4444, 1'b0);
        chk("t4_tap1_zero", rd_data[31:16], 0);
        do_frame(2'b11, 3, 3, 16'h5555, 16'h6666, 1'b0);

        // Second ADCLRCK edge three cycles after the first.
        do_frame(2'b00, 2, 5, 16'h7777, 16'h8888, 1'b1);
        chk("t5_overrun_sticky", overrun, 1);
        do_frame(2'b00, 2, 5, 16'h9999, 16'hAAAA, 1'b0);

        // Tap1 delay beyond the region, run past a full pointer wrap.
        for (int f = 0; f < 140; f++) begin
            logic [1:0] dis;
            dis = {1'b0, ($urandom_range(0, 5) == 0)};
            do_frame(dis, int'($urandom_range(0, 255)), 200, 16'($urandom), 16'($urandom), 1'b0);
        end

        // Reset while tap1 is in its WAIT cycle.
        delay_time = {8'd7, 8'd9}; wr_data = {16'hBEEF, 16'h1234}; disabled = 2'b00;
        @(negedge clk); #1 adc = 1'b1;
        repeat (7) @(negedge clk);
        chk("t6_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_we", ram_we, 0);
        chk("t6_valid", rd_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_overrun", overrun, 0);
        chk("t6_addr", ram_addr, 0);
        chk("t6_rd_data", rd_data, 0);
        mdl_mem[0][mdl_wptr[0]] = 16'h1234;
        mdl_wptr[0] = 0; mdl_wptr[1] = 0;
        exp_ovr = 1'b0;
        adc = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_frame(2'b00, 3, 6, 16'hC0DE, 16'hD00D, 1'b0);
        do_frame(2'b00, 1, 1, 16'hE0E0, 16'hF0F0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
